// File: rtl/dff_fifo.sv
// Synchronous show-ahead FIFO built from flip-flop storage, with occupancy
// count and sticky overflow/underflow flags.
module dff_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic               empty,
  output logic               full,
  output logic [$clog2(DEPTH):0] count,
  output logic               overflow,
  output logic               underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_acc, pop_acc, wr_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign push_acc = push && (!full || pop);
  assign pop_acc  = pop && !empty;
  assign wr_en    = push_acc && !clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc && !pop_acc)      count_d = count_q + CNT_W'(1);
      else if (!push_acc && pop_acc) count_d = count_q - CNT_W'(1);
      if (push && full && !pop) overflow_d  = 1'b1;
      if (pop && empty)         underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only the control state decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_dff_fifo.sv
// Directed bench for dff_fifo: reset, fill/drain, overflow, underflow,
// wrap with full push+pop, and clear/asynchronous reset mid-stream.
module tb_dff_fifo;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        push;
  logic [15:0] push_data;
  logic        pop;
  logic [15:0] pop_data;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  dff_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data),
    .empty(empty), .full(full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; push = 1'b1; push_data = 16'h5555; pop = 1'b0;
    tick(); tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b, required 0", full); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count); end
    n_checks++; if (pop_data !== 16'h0000) begin n_fail++; $display("FAIL reset_pop_data: got %h, required 0000", pop_data); end
    n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b, required 00", {overflow, underflow}); end
    push = 1'b0;
    rst_n = 1'b1;
    tick();
    push = 1'b1; push_data = 16'h1234;
    tick();
    push = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL first_push_count: got %0d, required 1", count); end
    n_checks++; if (pop_data !== 16'h1234) begin n_fail++; $display("FAIL first_push_data: got %h, required 1234", pop_data); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL first_pop_empty: got %b, required 1", empty); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; push_data = 16'(i);
      tick();
    end
    push = 1'b0;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b, required 1", full); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d, required 4", count); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (pop_data !== 16'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h, required %h", i, pop_data, 16'(i)); end
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b, required 1", empty); end
    n_checks++; if (pop_data !== 16'h0000) begin n_fail++; $display("FAIL drain_pop_data: got %h, required 0000", pop_data); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; push_data = 16'(i);
      tick();
    end
    push_data = 16'h00FF;
    tick();
    push = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d, required 4", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if (pop_data !== 16'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h, required %h", i, pop_data, 16'(i)); end
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_no_underflow: got %b, required 0", underflow); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b, required 0", overflow); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b, required 1", underflow); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL unf_count: got %0d, required 0", count); end
    push = 1'b1; push_data = 16'hBEEF; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL empty_pushpop_count: got %0d, required 1", count); end
    n_checks++; if (pop_data !== 16'hBEEF) begin n_fail++; $display("FAIL empty_pushpop_data: got %h, required beef", pop_data); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b, required 1", underflow); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b, required 0", underflow); end
  endtask

  task automatic test_wrap();
    bit         ps [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    bit         pp [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1};
    logic [2:0] ec [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    logic [15:0] nxt_in  = 16'h0010;
    logic [15:0] nxt_out = 16'h0010;
    for (int c = 0; c < 11; c++) begin
      push = ps[c]; pop = pp[c]; push_data = nxt_in;
      if (ps[c]) nxt_in++;
      if (pp[c]) begin
        n_checks++; if (pop_data !== nxt_out) begin n_fail++; $display("FAIL wrap_data[c%0d]: got %h, required %h", c, pop_data, nxt_out); end
        nxt_out++;
      end
      tick();
      n_checks++; if (count !== ec[c]) begin n_fail++; $display("FAIL wrap_count[c%0d]: got %0d, required %0d", c, count, ec[c]); end
    end
    push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pop_data !== nxt_out) begin n_fail++; $display("FAIL wrap_drain[%0d]: got %h, required %h", i, pop_data, nxt_out); end
      nxt_out++;
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    n_checks++; if (nxt_out !== 16'h001A || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_end: got next=%h empty=%b, required next=001a empty=1", nxt_out, empty); end
    n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL wrap_flags: got %b, required 00", {overflow, underflow}); end
  endtask

  task automatic test_clr_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_data = 16'h00A0 + 16'(i);
      tick();
    end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL clr_pre_count: got %0d, required 3", count); end
    clr = 1'b1; push_data = 16'hDEAD;
    tick();
    clr = 1'b0; push = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL clr_count: got %0d, required 0", count); end
    n_checks++; if (empty !== 1'b1 || pop_data !== 16'h0000) begin n_fail++; $display("FAIL clr_empty: got empty=%b data=%h, required empty=1 data=0000", empty, pop_data); end
    n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_flags: got %b, required 00", {overflow, underflow}); end
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; push_data = 16'h00B0 + 16'(i);
      tick();
    end
    push = 1'b0;
    n_checks++; if (count !== 3'd2 || pop_data !== 16'h00B0) begin n_fail++; $display("FAIL arst_pre: got count=%0d data=%h, required count=2 data=00b0", count, pop_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d, required 0", count); end
    n_checks++; if (empty !== 1'b1 || pop_data !== 16'h0000) begin n_fail++; $display("FAIL arst_empty: got empty=%b data=%h, required empty=1 data=0000", empty, pop_data); end
    #2 rst_n = 1'b1;
    tick();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL arst_after: got %b, required 1", empty); end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_clr_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
